// File: rtl/tty_ctrl_pkg.sv
// Shared definitions for the glass-TTY sequencer: state encoding, control codes,
// default geometry and character-RAM address packing.
package tty_ctrl_pkg;

  localparam int unsigned DEF_COLS = 128;
  localparam int unsigned DEF_ROWS = 32;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;

  localparam logic [63:0] SPACE_WORD = {8{CH_SPACE}};

  typedef enum logic [2:0] {
    StIdle,
    StPut,
    StScrRd,
    StScrWr,
    StClr
  } tty_state_e;

  // Word address of (row, word-in-row); the row field is 6 bits wide with its MSB unused.
  function automatic logic [10:0] addr_pack(input logic [4:0] row, input logic [3:0] word);
    return {1'b0, 1'b0, row, word};
  endfunction

endpackage

// File: rtl/tty_ctrl_if.sv
// Character stream handshake plus the data-side port of the text-mode character RAM.
interface tty_ctrl_if;

  logic        ch_valid;
  logic [7:0]  ch_data;
  logic        ch_ready;
  logic        ram_en;
  logic [7:0]  ram_we;
  logic [10:0] ram_addr;
  logic [63:0] ram_wdata;
  logic [63:0] ram_rdata;

  // The sequencer side: consumes characters, masters the RAM port.
  modport master (
    input  ch_valid, ch_data, ram_rdata,
    output ch_ready, ram_en, ram_we, ram_addr, ram_wdata
  );

  // The environment side: character source and the RAM itself.
  modport slave (
    output ch_valid, ch_data, ram_rdata,
    input  ch_ready, ram_en, ram_we, ram_addr, ram_wdata
  );

endinterface

// File: rtl/tty_ctrl.sv
// Glass-TTY sequencer: turns an ASCII byte stream into character-RAM word writes,
// tracks the cursor, and scrolls by copying rows up and blanking the last row.
module tty_ctrl
  import tty_ctrl_pkg::*;
#(
  parameter int unsigned COLS = DEF_COLS,
  parameter int unsigned ROWS = DEF_ROWS
) (
  input  logic        clk_data,
  input  logic        irst,
  tty_ctrl_if.master  bus,
  output logic        busy,
  output logic [6:0]  cursor_col,
  output logic [4:0]  cursor_row
);

  localparam int unsigned WPR       = COLS / 8;
  localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
  localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);
  localparam logic [3:0]  LAST_WORD = 4'(WPR - 1);

  tty_state_e state_q;
  logic [4:0] src_q;         // scroll source row, or row being blanked
  logic [3:0] word_q;        // word within the current row
  logic       scroll_pend_q; // a PUT wrapped off the last row; scroll right after it
  logic       clr_all_q;     // CLR is a form feed, so home the cursor when done

  logic accept;
  logic is_print;

  assign accept   = bus.ch_valid & bus.ch_ready;
  assign is_print = (bus.ch_data >= 8'h20) && (bus.ch_data <= 8'h7E);

  // Single FSM: state, counters, cursor and every port output are registered here.
  always_ff @(posedge clk_data) begin
    if (irst) begin
      state_q       <= StIdle;
      src_q         <= '0;
      word_q        <= '0;
      scroll_pend_q <= 1'b0;
      clr_all_q     <= 1'b0;
      cursor_col    <= '0;
      cursor_row    <= '0;
      busy          <= 1'b0;
      bus.ch_ready  <= 1'b0;
      bus.ram_en    <= 1'b0;
      bus.ram_we    <= '0;
      bus.ram_addr  <= '0;
      bus.ram_wdata <= '0;
    end else begin
      // No RAM access unless a branch below issues one.
      bus.ram_en <= 1'b0;
      bus.ram_we <= '0;

      unique case (state_q)
        StIdle: begin
          bus.ch_ready <= 1'b1;
          busy         <= 1'b0;
          if (accept) begin
            if (is_print) begin
              state_q       <= StPut;
              bus.ch_ready  <= 1'b0;
              busy          <= 1'b1;
              bus.ram_en    <= 1'b1;
              bus.ram_we    <= 8'd1 << cursor_col[2:0];
              bus.ram_addr  <= addr_pack(cursor_row, cursor_col[6:3]);
              bus.ram_wdata <= {8{bus.ch_data}};
              if (cursor_col == LAST_COL) begin
                cursor_col <= '0;
                if (cursor_row == LAST_ROW) begin
                  scroll_pend_q <= 1'b1;
                end else begin
                  cursor_row <= cursor_row + 5'd1;
                end
              end else begin
                cursor_col <= cursor_col + 7'd1;
              end
            end else if (bus.ch_data == CH_LF) begin
              cursor_col <= '0;
              if (cursor_row == LAST_ROW) begin
                state_q      <= StScrRd;
                src_q        <= 5'd1;
                word_q       <= '0;
                bus.ch_ready <= 1'b0;
                busy         <= 1'b1;
                bus.ram_en   <= 1'b1;
                bus.ram_addr <= addr_pack(5'd1, 4'd0);
              end else begin
                cursor_row <= cursor_row + 5'd1;
              end
            end else if (bus.ch_data == CH_CR) begin
              cursor_col <= '0;
            end else if (bus.ch_data == CH_BS) begin
              if (cursor_col != '0) begin
                cursor_col <= cursor_col - 7'd1;
              end
            end else if (bus.ch_data == CH_FF) begin
              state_q       <= StClr;
              clr_all_q     <= 1'b1;
              src_q         <= '0;
              word_q        <= '0;
              bus.ch_ready  <= 1'b0;
              busy          <= 1'b1;
              bus.ram_en    <= 1'b1;
              bus.ram_we    <= 8'hFF;
              bus.ram_addr  <= addr_pack(5'd0, 4'd0);
              bus.ram_wdata <= SPACE_WORD;
            end
          end
        end

        StPut: begin
          if (scroll_pend_q) begin
            scroll_pend_q <= 1'b0;
            state_q       <= StScrRd;
            src_q         <= 5'd1;
            word_q        <= '0;
            bus.ram_en    <= 1'b1;
            bus.ram_addr  <= addr_pack(5'd1, 4'd0);
          end else begin
            state_q      <= StIdle;
            bus.ch_ready <= 1'b1;
            busy         <= 1'b0;
          end
        end

        StScrRd: begin
          // Read data lands on ram_rdata at this edge; forward it one row up.
          state_q       <= StScrWr;
          bus.ram_en    <= 1'b1;
          bus.ram_we    <= 8'hFF;
          bus.ram_addr  <= addr_pack(src_q - 5'd1, word_q);
          bus.ram_wdata <= bus.ram_rdata;
        end

        StScrWr: begin
          bus.ram_en <= 1'b1;
          if (word_q == LAST_WORD) begin
            word_q <= '0;
            if (src_q == LAST_ROW) begin
              state_q       <= StClr;
              clr_all_q     <= 1'b0;
              bus.ram_we    <= 8'hFF;
              bus.ram_addr  <= addr_pack(LAST_ROW, 4'd0);
              bus.ram_wdata <= SPACE_WORD;
            end else begin
              state_q      <= StScrRd;
              src_q        <= src_q + 5'd1;
              bus.ram_addr <= addr_pack(src_q + 5'd1, 4'd0);
            end
          end else begin
            state_q      <= StScrRd;
            word_q       <= word_q + 4'd1;
            bus.ram_addr <= addr_pack(src_q, word_q + 4'd1);
          end
        end

        StClr: begin
          if ((src_q == LAST_ROW) && (word_q == LAST_WORD)) begin
            state_q      <= StIdle;
            bus.ch_ready <= 1'b1;
            busy         <= 1'b0;
            clr_all_q    <= 1'b0;
            if (clr_all_q) begin
              cursor_col <= '0;
              cursor_row <= '0;
            end
          end else begin
            bus.ram_en    <= 1'b1;
            bus.ram_we    <= 8'hFF;
            bus.ram_wdata <= SPACE_WORD;
            if (word_q == LAST_WORD) begin
              word_q       <= '0;
              src_q        <= src_q + 5'd1;
              bus.ram_addr <= addr_pack(src_q + 5'd1, 4'd0);
            end else begin
              word_q       <= word_q + 4'd1;
              bus.ram_addr <= addr_pack(src_q, word_q + 4'd1);
            end
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tty_ctrl.sv
// Bench for tty_ctrl: a character-grid model of the screen and cursor, a
// falling-edge RAM, and per-character checks of cursor, timing and RAM contents.
module tb_tty_ctrl;
  import tty_ctrl_pkg::*;

  logic       clk_data = 1'b0;
  logic       irst = 1'b1;
  logic       busy;
  logic [6:0] cursor_col;
  logic [4:0] cursor_row;

  tty_ctrl_if bus ();

  tty_ctrl #(
    .COLS(128),
    .ROWS(32)
  ) dut (
    .clk_data  (clk_data),
    .irst      (irst),
    .bus       (bus),
    .busy      (busy),
    .cursor_col(cursor_col),
    .cursor_row(cursor_row)
  );

  always #5 clk_data = ~clk_data;

  int total = 0;
  int bad   = 0;

  logic [63:0] mem [0:2047];
  int          en_total = 0;
  int          we_viol  = 0;

  logic [7:0] scr_m [0:31][0:127];
  int         m_col = 0;
  int         m_row = 0;

  // Character RAM: samples the port on the falling edge, read-before-write.
  always @(negedge clk_data) begin
    if (bus.ram_en) begin
      bus.ram_rdata = mem[bus.ram_addr];
      for (int i = 0; i < 8; i++) begin
        if (bus.ram_we[i]) mem[bus.ram_addr][i*8+:8] = bus.ram_wdata[i*8+:8];
      end
      en_total++;
    end else if (bus.ram_we != 8'h00) begin
      we_viol++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_data);
    #1;
  endtask

  task automatic model_newline();
    if (m_row < 31) begin
      m_row++;
    end else begin
      for (int r = 0; r < 31; r++)
        for (int c = 0; c < 128; c++) scr_m[r][c] = scr_m[r+1][c];
      for (int c = 0; c < 128; c++) scr_m[31][c] = 8'h20;
    end
  endtask

  // Compare the whole visible screen; reports the first differing word if any.
  task automatic check_screen(input string tag);
    logic [63:0] e;
    logic [63:0] got_w;
    logic [63:0] exp_w;
    int          a;
    a = -1;
    for (int r = 0; r < 32; r++) begin
      for (int w = 0; w < 16; w++) begin
        for (int i = 0; i < 8; i++) e[i*8+:8] = scr_m[r][w*8+i];
        if (a < 0 && mem[r*16+w] !== e) begin
          a = r * 16 + w; got_w = mem[a]; exp_w = e;
        end
        if (a < 0 && r == 31 && w == 15) begin
          got_w = mem[511]; exp_w = e;
        end
      end
    end
    if (a < 0) a = 511;
    check($sformatf("%s_word%0d", tag, a), got_w, exp_w);
  endtask

  task automatic send(input logic [7:0] c);
    int          k;
    int          en_n;
    int          busy_n;
    int          exp_lat;
    int          exp_en;
    bit          print;
    bit          scr;
    logic [10:0] a1;
    logic [7:0]  we1;
    logic [63:0] d1;
    logic        en1;

    k = 0;
    while (bus.ch_ready !== 1'b1 && k < 3000) begin tick(); k++; end
    if (k >= 3000) check("ready_wait", bus.ch_ready, 1'b1);

    print = (c >= 8'h20) && (c <= 8'h7E);
    scr   = (print && m_col == 127 && m_row == 31) || (c == CH_LF && m_row == 31);
    if (print) begin
      exp_lat = scr ? 2 + 1008 : 2;
      exp_en  = scr ? 1 + 1008 : 1;
    end else if (c == CH_LF) begin
      exp_lat = scr ? 1 + 1008 : 1;
      exp_en  = scr ? 1008 : 0;
    end else if (c == CH_FF) begin
      exp_lat = 1 + 512;
      exp_en  = 512;
    end else begin
      exp_lat = 1;
      exp_en  = 0;
    end

    bus.ch_valid = 1'b1;
    bus.ch_data  = c;
    tick();
    bus.ch_valid = 1'b0;
    en1 = bus.ram_en; a1 = bus.ram_addr; we1 = bus.ram_we; d1 = bus.ram_wdata;
    k = 1; en_n = 0; busy_n = 0;
    while (bus.ch_ready !== 1'b1 && k < 3000) begin
      if (bus.ram_en) en_n++;
      if (busy) busy_n++;
      tick();
      k++;
    end

    if (print) begin
      check("put_addr", a1, 64'(m_row * 16 + m_col / 8));
      check("put_we", we1, 64'(1 << (m_col % 8)));
      check("put_data", d1, {8{c}});
    end else if (c == CH_FF) begin
      check("ff_addr", a1, 64'd0);
      check("ff_we", we1, 64'hFF);
      check("ff_data", d1, SPACE_WORD);
    end else if (scr) begin
      check("scr_first_addr", a1, 64'd16);
      check("scr_first_we", we1, 64'd0);
    end else begin
      check("no_ram_en", en1, 1'b0);
    end
    check($sformatf("latency_%02h", c), k, exp_lat);
    check($sformatf("ram_cycles_%02h", c), en_n, exp_en);
    check($sformatf("busy_cycles_%02h", c), busy_n, exp_en);

    if (print) begin
      scr_m[m_row][m_col] = c;
      if (m_col == 127) begin m_col = 0; model_newline(); end
      else m_col++;
    end else if (c == CH_LF) begin
      m_col = 0; model_newline();
    end else if (c == CH_CR) begin
      m_col = 0;
    end else if (c == CH_BS) begin
      if (m_col > 0) m_col--;
    end else if (c == CH_FF) begin
      for (int r = 0; r < 32; r++)
        for (int j = 0; j < 128; j++) scr_m[r][j] = 8'h20;
      m_col = 0; m_row = 0;
    end

    check("cursor_col", cursor_col, 64'(m_col));
    check("cursor_row", cursor_row, 64'(m_row));
    if (exp_en != 0) check_screen("screen");
  endtask

  initial begin
    int          p;
    int          base;
    logic [7:0]  c;

    bus.ch_valid = 1'b0;
    bus.ch_data  = 8'h00;
    for (int a = 0; a < 2048; a++) mem[a] = '0;
    for (int r = 0; r < 32; r++)
      for (int j = 0; j < 128; j++) scr_m[r][j] = 8'h00;

    // Reset state
    repeat (3) tick();
    check("rst_ready", bus.ch_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_col", cursor_col, 0);
    check("rst_row", cursor_row, 0);
    check("rst_en", bus.ram_en, 1'b0);
    check("rst_we", bus.ram_we, 0);
    check("rst_addr", bus.ram_addr, 0);
    check("rst_wdata", bus.ram_wdata, 0);
    irst = 1'b0;
    tick();
    check("ready_after_rst", bus.ch_ready, 1'b1);

    // 'A', then advance to column 9, 'Z', two BS and CR
    send(8'h41);
    for (int i = 0; i < 8; i++) send(8'(8'h42 + i));
    send(8'h5A);
    send(CH_BS);
    send(CH_BS);
    send(CH_CR);

    // Form feed, then fill row 0 exactly
    send(CH_FF);
    for (int i = 0; i < 128; i++) send(8'(8'h21 + (i % 94)));

    // Walk to the last row, preload a row-number pattern and scroll
    while (m_row < 31) send(CH_LF);
    for (int r = 0; r < 32; r++) begin
      for (int w = 0; w < 16; w++) mem[r*16+w] = {8{8'(r)}};
      for (int j = 0; j < 128; j++) scr_m[r][j] = 8'(r);
    end
    send(CH_LF);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      p = $urandom_range(0, 99);
      if (p < 72)      c = 8'($urandom_range(32, 126));
      else if (p < 80) c = CH_LF;
      else if (p < 85) c = CH_CR;
      else if (p < 91) c = CH_BS;
      else if (p < 93) c = CH_FF;
      else             c = 8'($urandom_range(0, 255));
      send(c);
    end

    // Reset in the middle of a scroll
    while (m_row < 31) send(CH_LF);
    bus.ch_valid = 1'b1;
    bus.ch_data  = CH_LF;
    tick();
    bus.ch_valid = 1'b0;
    repeat (300) tick();
    check("mid_busy_before", busy, 1'b1);
    irst = 1'b1;
    tick();
    check("mid_rst_en", bus.ram_en, 1'b0);
    check("mid_rst_we", bus.ram_we, 0);
    check("mid_rst_col", cursor_col, 0);
    check("mid_rst_row", cursor_row, 0);
    check("mid_rst_busy", busy, 1'b0);
    base = en_total;
    tick();
    irst = 1'b0;
    tick();
    check("mid_ready_after", bus.ch_ready, 1'b1);
    repeat (20) tick();
    check("mid_no_ram_cycles", en_total, base);

    // Resume from the memory as the abort left it
    m_col = 0; m_row = 0;
    for (int r = 0; r < 32; r++)
      for (int w = 0; w < 16; w++)
        for (int i = 0; i < 8; i++) scr_m[r][w*8+i] = mem[r*16+w][i*8+:8];
    send(8'h51);
    send(CH_LF);

    check("we_without_en", we_viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
